// File: rtl/counter_arbiter.sv
// Two-requester round-robin front end for a shared up/down/load/preset counter.
// Optional saturation guard: define COUNTER_ARB_SATGUARD_EN.
module counter_arbiter #(
   parameter int N = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         a_valid,
   input  logic [1:0]   a_op,
   input  logic [N-1:0] a_data,
   output logic         a_ready,
   input  logic         b_valid,
   input  logic [1:0]   b_op,
   input  logic [N-1:0] b_data,
   output logic         b_ready,
   output logic         cnt_en,
   output logic         cnt_up,
   output logic         cnt_down,
   output logic         cnt_load,
   output logic         cnt_preset,
   output logic [N-1:0] cnt_ldata,
   input  logic [N-1:0] cnt_value,
   input  logic         cnt_max,
   input  logic         cnt_min,
   output logic         rsp_valid,
   output logic         rsp_id,
   output logic [N-1:0] rsp_count,
   output logic         rsp_err
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ISSUE  = 2'd1,
      S_SETTLE = 2'd2,
      S_RESP   = 2'd3
   } state_t;

   typedef enum logic [1:0] {
      OP_UP     = 2'b00,
      OP_DOWN   = 2'b01,
      OP_LOAD   = 2'b10,
      OP_PRESET = 2'b11
   } op_t;

   state_t       r_state;
   state_t       w_next;
   logic         r_last;      // 1: B was granted last, so A wins a tie
   logic [1:0]   r_op;
   logic [N-1:0] r_data;
   logic         r_id;
   logic         r_rsp_id;
   logic [N-1:0] r_rsp_count;
   logic         w_a_grant;
   logic         w_b_grant;
   logic         w_guard;

   // Reset gates the grants so ready stays low while reset is held.
   assign w_a_grant = reset && a_valid && (!b_valid || r_last);
   assign w_b_grant = reset && b_valid && (!a_valid || !r_last);

`ifdef COUNTER_ARB_SATGUARD_EN
   logic r_err;
   logic r_rsp_err;

   assign w_guard = (r_state == S_ISSUE) &&
                    (((r_op == OP_UP) && cnt_max) || ((r_op == OP_DOWN) && cnt_min));
   assign rsp_err = r_rsp_err;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_err     <= 1'b0;
         r_rsp_err <= 1'b0;
      end else begin
         if (r_state == S_ISSUE)  r_err     <= w_guard;
         if (r_state == S_SETTLE) r_rsp_err <= r_err;
      end
   end
`else
   logic w_unused;

   assign w_guard  = 1'b0;
   assign rsp_err  = 1'b0;
   assign w_unused = cnt_max | cnt_min;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next     = r_state;
      a_ready    = 1'b0;
      b_ready    = 1'b0;
      cnt_en     = 1'b0;
      cnt_up     = 1'b0;
      cnt_down   = 1'b0;
      cnt_load   = 1'b0;
      cnt_preset = 1'b0;
      cnt_ldata  = '0;
      rsp_valid  = 1'b0;
      case (r_state)
         S_IDLE: begin
            a_ready = w_a_grant;
            b_ready = w_b_grant;
            if (w_a_grant || w_b_grant) w_next = S_ISSUE;
         end
         S_ISSUE: begin
            cnt_ldata = r_data;
            if (!w_guard) begin
               cnt_en = 1'b1;
               case (r_op)
                  OP_UP:   cnt_up     = 1'b1;
                  OP_DOWN: cnt_down   = 1'b1;
                  OP_LOAD: cnt_load   = 1'b1;
                  default: cnt_preset = 1'b1;
               endcase
            end
            w_next = S_SETTLE;
         end
         S_SETTLE: w_next = S_RESP;
         S_RESP: begin
            rsp_valid = 1'b1;
            w_next    = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_last      <= 1'b1;
         r_op        <= 2'b00;
         r_data      <= '0;
         r_id        <= 1'b0;
         r_rsp_id    <= 1'b0;
         r_rsp_count <= '0;
      end else begin
         if ((r_state == S_IDLE) && (w_a_grant || w_b_grant)) begin
            r_id   <= w_b_grant;
            r_last <= w_b_grant;
            r_op   <= w_b_grant ? b_op   : a_op;
            r_data <= w_b_grant ? b_data : a_data;
         end
         // Response fields are separate from the command latch so they hold until the next RESP.
         if (r_state == S_SETTLE) begin
            r_rsp_count <= cnt_value;
            r_rsp_id    <= r_id;
         end
      end
   end

   assign rsp_id    = r_rsp_id;
   assign rsp_count = r_rsp_count;

endmodule
